// File: rtl/prime_pkg.sv
// Shared types for the prime bitmap RAM arbiter: owner encoding and the read tag.
package prime_pkg;

    localparam int PRIME_AW = 20;

    typedef enum logic {
        OWN_S = 1'b0,
        OWN_P = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
        logic   fwd_hit;
        logic   fwd_dat;
    } tag_t;

endpackage

// File: rtl/prime_ram_fwd.sv
// Write history for the bitmap RAM plus the match/priority select that lets a
// read see writes the RAM has not yet absorbed.
module prime_ram_fwd
    import prime_pkg::*;
#(
    parameter int AW      = PRIME_AW,
    parameter int FWD_WIN = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          hit,
    output logic          dat
);

    localparam int DEPTH = (FWD_WIN > 0) ? FWD_WIN : 1;

    // Entry 0 is the write presented one cycle ago, entry DEPTH-1 the oldest.
    logic [DEPTH-1:0] h_vld;
    logic [DEPTH-1:0] h_dat;
    logic [AW-1:0]    h_addr [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_vld <= '0;
            h_dat <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                h_addr[i] <= '0;
            end
        end else begin
            h_vld[0]  <= we;
            h_dat[0]  <= wdata;
            h_addr[0] <= waddr;
            for (int i = 1; i < DEPTH; i++) begin
                h_vld[i]  <= h_vld[i-1];
                h_dat[i]  <= h_dat[i-1];
                h_addr[i] <= h_addr[i-1];
            end
        end
    end

    // Scan oldest to newest so the most recent matching write is the one kept.
    always_comb begin
        hit = 1'b0;
        dat = 1'b0;
        if (FWD_WIN > 0) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (h_vld[i] && (h_addr[i] == raddr)) begin
                    hit = 1'b1;
                    dat = h_dat[i];
                end
            end
            if (we && (waddr == raddr)) begin
                hit = 1'b1;
                dat = wdata;
            end
        end
    end

endmodule

// File: rtl/prime_ram_arbiter.sv
// Shares the bitmap RAM read port between the sieve engine (S) and the prime
// scanner (P); passes S writes through and routes tagged read data back.
module prime_ram_arbiter
    import prime_pkg::*;
#(
    parameter int AW      = PRIME_AW,
    parameter int RD_LAT  = 2,
    parameter int FWD_WIN = 2,
    parameter int STRICT  = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_req,
    input  logic [AW-1:0] s_addr,
    output logic          s_gnt,
    output logic          s_rvalid,
    output logic          s_rdata,
    input  logic          s_we,
    input  logic [AW-1:0] s_waddr,
    input  logic          s_wdata,
    input  logic          p_req,
    input  logic [AW-1:0] p_addr,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic          p_rdata,
    output logic          ram_wea,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic          ram_rdata,
    output logic          busy
);

    logic   last_p;
    logic   s_win;
    logic   issue_vld;
    owner_e issue_own;
    logic   fwd_hit;
    logic   fwd_dat;
    logic   s_rdata_q;
    logic   p_rdata_q;
    logic   resp_dat;
    tag_t   pipe [RD_LAT];
    tag_t   out_tag;

    // Grants are held off while reset is asserted so the outputs read 0.
    always_comb begin
        s_win = 1'b0;
        if (rstn && s_req) begin
            s_win = !p_req || (STRICT != 0) || last_p;
        end
    end

    assign s_gnt = s_win;
    assign p_gnt = rstn && p_req && !s_win;

    prime_ram_fwd #(
        .AW      (AW),
        .FWD_WIN (FWD_WIN)
    ) u_fwd (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_wea),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .hit   (fwd_hit),
        .dat   (fwd_dat)
    );

    // issue_vld/issue_own accompany ram_raddr; the forwarding result is
    // folded in as the tag leaves that stage for the latency pipe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_p    <= 1'b1;
            ram_raddr <= '0;
            issue_vld <= 1'b0;
            issue_own <= OWN_S;
            ram_wea   <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= 1'b0;
            s_rdata_q <= 1'b0;
            p_rdata_q <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            if (s_gnt || p_gnt) begin
                ram_raddr <= s_gnt ? s_addr : p_addr;
                last_p    <= p_gnt;
            end
            issue_vld <= s_gnt || p_gnt;
            issue_own <= p_gnt ? OWN_P : OWN_S;
            ram_wea   <= s_we;
            ram_waddr <= s_waddr;
            ram_wdata <= s_wdata;
            pipe[0].vld     <= issue_vld;
            pipe[0].own     <= issue_own;
            pipe[0].fwd_hit <= issue_vld && fwd_hit;
            pipe[0].fwd_dat <= issue_vld && fwd_dat;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
            s_rdata_q <= s_rdata;
            p_rdata_q <= p_rdata;
        end
    end

    assign out_tag  = pipe[RD_LAT-1];
    assign resp_dat = out_tag.fwd_hit ? out_tag.fwd_dat : ram_rdata;
    assign s_rvalid = out_tag.vld && (out_tag.own == OWN_S);
    assign p_rvalid = out_tag.vld && (out_tag.own == OWN_P);
    assign s_rdata  = s_rvalid ? resp_dat : s_rdata_q;
    assign p_rdata  = p_rvalid ? resp_dat : p_rdata_q;

    always_comb begin
        busy = issue_vld;
        for (int k = 0; k < RD_LAT; k++) begin
            busy = busy | pipe[k].vld;
        end
    end

endmodule
